// File: rtl/pc_stack.sv
// Program counter with increment, load, and call/return through a LIFO return-address stack.
// Optional relative Load enabled by defining PC_STACK_REL_BRANCH_EN.
module pc_stack #(
  parameter int WIDTH      = 5,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic                       Clear,
  input  logic                       Up,
  input  logic                       Load,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic                       Rel,
  input  logic [WIDTH-1:0]           Target,
  input  logic [WIDTH-1:0]           Offset,
  output logic [WIDTH-1:0]           O,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       StackFull,
  output logic                       StackEmpty,
  output logic                       Fault
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] o_reg, o_next;
  logic [LW-1:0]    level_reg, level_next;
  logic             fault_reg, fault_next;
  logic [WIDTH-1:0] stack_reg [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] load_val;
  logic [PW-1:0]    push_idx;
  logic [PW-1:0]    pop_idx;
  logic             push_en;
  logic             full;
  logic             empty;

  assign pc_inc   = o_reg + WIDTH'(1);
  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  // Push index is only used when not full, so it always fits the entry index.
  assign push_idx = PW'(level_reg);
  assign pop_idx  = PW'(level_reg - LW'(1));

`ifdef PC_STACK_REL_BRANCH_EN
  // Same-width add of the two's-complement offset gives sign extension and wrap for free.
  assign load_val = Rel ? (o_reg + Offset) : Target;
`else
  assign load_val = Target;
  logic unused_rel;
  assign unused_rel = &{1'b0, Rel, Offset};
`endif

  always_comb begin
    o_next     = o_reg;
    level_next = level_reg;
    fault_next = fault_reg;
    push_en    = 1'b0;
    if (Clear) begin
      o_next     = WIDTH'(RESET_ADDR);
      level_next = '0;
      fault_next = 1'b0;
    end else if (Ret) begin
      if (empty) begin
        fault_next = 1'b1;
      end else begin
        o_next     = stack_reg[pop_idx];
        level_next = level_reg - LW'(1);
      end
    end else if (Call) begin
      if (full) begin
        fault_next = 1'b1;
      end else begin
        push_en    = 1'b1;
        level_next = level_reg + LW'(1);
        o_next     = Target;
      end
    end else if (Load) begin
      o_next = load_val;
    end else if (Up) begin
      o_next = pc_inc;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      o_reg     <= WIDTH'(RESET_ADDR);
      level_reg <= '0;
      fault_reg <= 1'b0;
    end else begin
      o_reg     <= o_next;
      level_reg <= level_next;
      fault_reg <= fault_next;
    end
  end

  // Each entry owns its own register so the write decode stays per-slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        stack_reg[gi] <= '0;
      end else if (push_en && (push_idx == PW'(gi))) begin
        stack_reg[gi] <= pc_inc;
      end
    end
  end

  assign O          = o_reg;
  assign Level      = level_reg;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign Fault      = fault_reg;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (WIDTH=5, DEPTH=4): directed plan plus random commands
// against a queue-based reference model.
module tb_pc_stack;

  localparam int W = 5;
  localparam int D = 4;
  localparam int MOD = 32;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         Clear = 0, Up = 0, Load = 0, Call = 0, Ret = 0, Rel = 0;
  logic [W-1:0] Target = '0, Offset = '0;
  logic [W-1:0] O;
  logic [2:0]   Level;
  logic         StackFull, StackEmpty, Fault;

  int checks = 0;
  int errors = 0;

  int m_pc = 0;
  bit m_fault = 0;
  int m_stack[$];

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(0)) dut (
    .Clock(Clock), .ResetN(ResetN), .Clear(Clear), .Up(Up), .Load(Load),
    .Call(Call), .Ret(Ret), .Rel(Rel), .Target(Target), .Offset(Offset),
    .O(O), .Level(Level), .StackFull(StackFull), .StackEmpty(StackEmpty), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".O"}, int'(O), m_pc);
    check({tag, ".Level"}, int'(Level), m_stack.size());
    check({tag, ".Full"}, int'(StackFull), int'(m_stack.size() == D));
    check({tag, ".Empty"}, int'(StackEmpty), int'(m_stack.size() == 0));
    check({tag, ".Fault"}, int'(Fault), int'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_fault = 0;
    m_stack.delete();
  endtask

  // Reference behaviour straight from the command rules, priority Clear > Ret > Call > Load > Up.
  task automatic model_apply(input bit clr, up, ld, cl, rt, rl, input int tgt, off);
    int soff;
    if (clr) begin
      model_reset();
    end else if (rt) begin
      if (m_stack.size() == 0) m_fault = 1;
      else m_pc = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == D) m_fault = 1;
      else begin
        m_stack.push_back((m_pc + 1) % MOD);
        m_pc = tgt;
      end
    end else if (ld) begin
`ifdef PC_STACK_REL_BRANCH_EN
      if (rl) begin
        soff = (off >= MOD / 2) ? off - MOD : off;
        m_pc = ((m_pc + soff) % MOD + MOD) % MOD;
      end else m_pc = tgt;
`else
      soff = rl ? off : 0;
      m_pc = tgt + soff * 0;
`endif
    end else if (up) begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic step(input string tag, input bit clr, up, ld, cl, rt, rl,
                      input logic [W-1:0] tgt, off);
    Clear = clr; Up = up; Load = ld; Call = cl; Ret = rt; Rel = rl;
    Target = tgt; Offset = off;
    @(posedge Clock);
    model_apply(clr, up, ld, cl, rt, rl, int'(tgt), int'(off));
    #1;
    $display("step %-8s clr=%0b up=%0b ld=%0b call=%0b ret=%0b rel=%0b tgt=%02h off=%02h -> O=%02h Level=%0d Fault=%0b",
             tag, clr, up, ld, cl, rt, rl, tgt, off, O, Level, Fault);
    check_all(tag);
  endtask

  initial begin
    // Reset held: state stays at reset values even with Up asserted.
    Up = 1;
    #12;
    check_all("rst");
    @(posedge Clock); #1;
    check("rst_hold.O", int'(O), 0);
    Up = 0;
    @(negedge Clock);
    ResetN = 1;
    model_reset();

    // Count through the full range and wrap.
    for (int i = 0; i < 33; i++) step("up", 0, 1, 0, 0, 0, 0, 5'h00, 5'h00);
    check("wrap.O", int'(O), 1);

    // Load, call, increments, return.
    step("load", 0, 0, 1, 0, 0, 0, 5'h10, 5'h00); check("ld.O", int'(O), 'h10);
    step("call", 0, 0, 0, 1, 0, 0, 5'h08, 5'h00); check("call.O", int'(O), 'h08);
    step("up", 0, 1, 0, 0, 0, 0, 5'h00, 5'h00);
    step("up", 0, 1, 0, 0, 0, 0, 5'h00, 5'h00);  check("up2.O", int'(O), 'h0A);
    step("ret", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00);  check("ret.O", int'(O), 'h11);

    // Nested calls, overflow, unwinding, underflow, clear.
    step("load", 0, 0, 1, 0, 0, 0, 5'h03, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h04, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h08, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h0C, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h10, 5'h00);
    step("ovf", 0, 0, 0, 1, 0, 0, 5'h1F, 5'h00);
    check("ovf.O", int'(O), 'h10);
    check("ovf.Fault", int'(Fault), 1);
    check("ovf.Full", int'(StackFull), 1);
    step("ret", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00); check("r1.O", int'(O), 'h0D);
    step("ret", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00); check("r2.O", int'(O), 'h09);
    step("ret", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00); check("r3.O", int'(O), 'h05);
    step("ret", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00); check("r4.O", int'(O), 'h04);
    step("unf", 0, 0, 0, 0, 1, 0, 5'h00, 5'h00);
    check("unf.O", int'(O), 'h04);
    check("unf.Fault", int'(Fault), 1);
    step("clear", 1, 0, 0, 0, 0, 0, 5'h00, 5'h00);
    check("clr.Fault", int'(Fault), 0);

    // Priority.
    step("call", 0, 0, 0, 1, 0, 0, 5'h07, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h0B, 5'h00);
    step("allhi", 1, 1, 1, 1, 1, 0, 5'h15, 5'h00);
    check("prio.O", int'(O), 0);
    check("prio.Level", int'(Level), 0);
    step("call", 0, 0, 0, 1, 0, 0, 5'h05, 5'h00);
    step("ret+up", 0, 1, 0, 0, 1, 0, 5'h00, 5'h00);
    check("retup.O", int'(O), 1);

    // Asynchronous reset between edges.
    step("call", 0, 0, 0, 1, 0, 0, 5'h0A, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h0B, 5'h00);
    step("call", 0, 0, 0, 1, 0, 0, 5'h17, 5'h00);
    check("pre_arst.O", int'(O), 'h17);
    #2;
    ResetN = 0;
    #1;
    check("arst.O", int'(O), 0);
    check("arst.Level", int'(Level), 0);
    model_reset();
    check_all("arst");
    @(negedge Clock);
    ResetN = 1;

    // Relative vs absolute load.
    step("load", 0, 0, 1, 0, 0, 0, 5'h02, 5'h00);
    step("rel-2", 0, 0, 1, 0, 0, 1, 5'h1E, 5'h1E);
`ifdef PC_STACK_REL_BRANCH_EN
    check("rel1.O", int'(O), 'h00);
`else
    check("rel1.O", int'(O), 'h1E);
`endif
    step("rel-1", 0, 0, 1, 0, 0, 1, 5'h1F, 5'h1F);
    check("rel2.O", int'(O), 'h1F);

    // Random commands against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
